// File: rtl/mux_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor built from a single
// mux-only full-adder slice, with valid/ready handshakes on both sides.

// 2:1 multiplexer: the only logic primitive used in the datapath.
module mux_2to1_slice (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module mux_serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, b_cap;
  logic [CW-1:0]    cnt;
  logic             carry, c_msb_in;

  logic accept, last_bit, commit, release_out;
  logic nb0, prop, nprop, sum_bit, cout_bit, ov_bit;

  logic             in_ready_nxt, out_valid_nxt, c_out_nxt, overflow_nxt;
  logic [WIDTH-1:0] result_nxt;

  assign accept      = (state == IDLE) && in_valid;
  assign last_bit    = (state == RUN) && (cnt == LAST_BIT);
  assign commit      = (state == DONE) && !out_valid;
  assign release_out = (state == DONE) && out_valid && out_ready;

  // Operand B is captured inverted for subtraction, selected per bit by a mux.
  for (genvar i = 0; i < WIDTH; i++) begin : g_binv
    mux_2to1_slice u_inv (.sel(sub), .d0(b[i]), .d1(~b[i]), .y(b_cap[i]));
  end

  // Mux-only full adder on the current LSBs: propagate, sum and carry-out.
  assign nb0 = ~b_sr[0];
  mux_2to1_slice u_prop  (.sel(a_sr[0]), .d0(b_sr[0]), .d1(nb0),     .y(prop));
  mux_2to1_slice u_nprop (.sel(a_sr[0]), .d0(nb0),     .d1(b_sr[0]), .y(nprop));
  mux_2to1_slice u_sum   (.sel(carry),   .d0(prop),    .d1(nprop),   .y(sum_bit));
  mux_2to1_slice u_cout  (.sel(prop),    .d0(a_sr[0]), .d1(carry),   .y(cout_bit));

  // Signed overflow: carry into MSB differs from carry out of MSB.
  mux_2to1_slice u_ovf (.sel(c_msb_in), .d0(carry), .d1(~carry), .y(ov_bit));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Output next values; the result is committed one cycle after the last bit.
  always_comb begin
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = out_valid;
    result_nxt    = result;
    c_out_nxt     = c_out;
    overflow_nxt  = overflow;
    if (commit) begin
      out_valid_nxt = 1'b1;
      result_nxt    = sum_sr;
      c_out_nxt     = carry;
      overflow_nxt  = ov_bit;
    end else if (release_out) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      result    <= result_nxt;
      c_out     <= c_out_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Serial datapath: operand shift registers, sum shifted in from the MSB side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_cap;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
      carry  <= cout_bit;
      if (last_bit) c_msb_in <= carry;
      else          cnt      <= cnt + CW'(1);
    end
  end

endmodule
